// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, immediate/control decode, load-use stall and ID/EX register.
// Optional DECODE_BYPASS_EN: write-first bypass from the writeback port into register reads.
module decode_cycle #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_decode_clk,
  input  logic        i_decode_reset_n,
  input  logic [31:0] i_decode_pc,
  input  logic [31:0] i_decode_inst,
  input  logic        i_decode_flush,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_decode_stall,
  output logic [31:0] o_ex_pc,
  output logic [31:0] o_ex_rs1_data,
  output logic [31:0] o_ex_rs2_data,
  output logic [31:0] o_ex_imm,
  output logic [4:0]  o_ex_rs1_addr,
  output logic [4:0]  o_ex_rs2_addr,
  output logic [4:0]  o_ex_rd,
  output logic [2:0]  o_ex_funct3,
  output logic [3:0]  o_ex_alu_op,
  output logic [1:0]  o_ex_wb_sel,
  output logic        o_ex_opa_sel,
  output logic        o_ex_opb_sel,
  output logic        o_ex_rd_wr,
  output logic        o_ex_mem_rd,
  output logic        o_ex_mem_wr,
  output logic        o_ex_is_branch,
  output logic        o_ex_is_jump,
  output logic        o_ex_valid
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_e;

  function automatic alu_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [31:0] regs [32];

  logic        known, rs1_used, rs2_used, stall, bubble;
  logic [31:0] dinst, rs1_data, rs2_data;
  logic        byp1, byp2;

  logic [31:0] d_imm;
  alu_e        d_alu;
  logic [1:0]  d_wb;
  logic        d_opa, d_opb, d_rd_wr, d_mem_rd, d_mem_wr, d_br, d_jmp;

  always_comb begin
    known    = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (i_decode_inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL:   rs1_used = 1'b0;
      OPC_OP, OPC_STORE, OPC_BRANCH: rs2_used = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: ;
      default:                       known = 1'b0;
    endcase
  end

  // Stall only looks at the load currently in ID/EX; a flush overrides it.
  assign stall = i_decode_reset_n & ~i_decode_flush & o_ex_mem_rd & (o_ex_rd != 5'd0) &
                 ((rs1_used & (i_decode_inst[19:15] == o_ex_rd)) |
                  (rs2_used & (i_decode_inst[24:20] == o_ex_rd)));
  assign o_decode_stall = stall;

  // Bubbles are produced by decoding NOP_INST and then squashing its side effects.
  assign bubble = i_decode_flush | stall | ~known;
  assign dinst  = bubble ? NOP_INST : i_decode_inst;

`ifdef DECODE_BYPASS_EN
  assign byp1 = i_wb_we & (i_wb_rd != 5'd0) & (i_wb_rd == dinst[19:15]);
  assign byp2 = i_wb_we & (i_wb_rd != 5'd0) & (i_wb_rd == dinst[24:20]);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rs1_data = (dinst[19:15] == 5'd0) ? '0 : byp1 ? i_wb_data : regs[dinst[19:15]];
  assign rs2_data = (dinst[24:20] == 5'd0) ? '0 : byp2 ? i_wb_data : regs[dinst[24:20]];

  always_comb begin
    d_imm    = '0;
    d_alu    = ALU_ADD;
    d_wb     = 2'd0;
    d_opa    = 1'b0;
    d_opb    = 1'b0;
    d_rd_wr  = 1'b0;
    d_mem_rd = 1'b0;
    d_mem_wr = 1'b0;
    d_br     = 1'b0;
    d_jmp    = 1'b0;
    case (dinst[6:0])
      OPC_LUI: begin
        d_imm = {dinst[31:12], 12'h000};
        d_alu = ALU_PASSB; d_opb = 1'b1; d_rd_wr = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = {dinst[31:12], 12'h000};
        d_opa = 1'b1; d_opb = 1'b1; d_rd_wr = 1'b1;
      end
      OPC_JAL: begin
        d_imm = {{11{dinst[31]}}, dinst[31], dinst[19:12], dinst[20], dinst[30:21], 1'b0};
        d_wb = 2'd2; d_jmp = 1'b1; d_opa = 1'b1; d_opb = 1'b1; d_rd_wr = 1'b1;
      end
      OPC_JALR: begin
        d_imm = {{20{dinst[31]}}, dinst[31:20]};
        d_wb = 2'd2; d_jmp = 1'b1; d_opb = 1'b1; d_rd_wr = 1'b1;
      end
      OPC_BRANCH: begin
        d_imm = {{19{dinst[31]}}, dinst[31], dinst[7], dinst[30:25], dinst[11:8], 1'b0};
        d_alu = ALU_SUB; d_br = 1'b1;
      end
      OPC_LOAD: begin
        d_imm = {{20{dinst[31]}}, dinst[31:20]};
        d_wb = 2'd1; d_mem_rd = 1'b1; d_opb = 1'b1; d_rd_wr = 1'b1;
      end
      OPC_STORE: begin
        d_imm = {{20{dinst[31]}}, dinst[31:25], dinst[11:7]};
        d_mem_wr = 1'b1; d_opb = 1'b1;
      end
      OPC_OPIMM: begin
        d_imm = {{20{dinst[31]}}, dinst[31:20]};
        d_alu = alu_of(dinst[14:12], dinst[30] & (dinst[14:12] == 3'b101));
        d_opb = 1'b1; d_rd_wr = 1'b1;
      end
      OPC_OP: begin
        d_alu = alu_of(dinst[14:12], dinst[30]);
        d_rd_wr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_decode_clk or negedge i_decode_reset_n) begin
    if (!i_decode_reset_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_wb_we && (i_wb_rd != 5'd0)) begin
      regs[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge i_decode_clk or negedge i_decode_reset_n) begin
    if (!i_decode_reset_n) begin
      o_ex_pc        <= '0;
      o_ex_rs1_data  <= '0;
      o_ex_rs2_data  <= '0;
      o_ex_imm       <= '0;
      o_ex_rs1_addr  <= '0;
      o_ex_rs2_addr  <= '0;
      o_ex_rd        <= '0;
      o_ex_funct3    <= '0;
      o_ex_alu_op    <= '0;
      o_ex_wb_sel    <= '0;
      o_ex_opa_sel   <= 1'b0;
      o_ex_opb_sel   <= 1'b0;
      o_ex_rd_wr     <= 1'b0;
      o_ex_mem_rd    <= 1'b0;
      o_ex_mem_wr    <= 1'b0;
      o_ex_is_branch <= 1'b0;
      o_ex_is_jump   <= 1'b0;
      o_ex_valid     <= 1'b0;
    end else begin
      o_ex_pc        <= i_decode_pc;
      o_ex_rs1_data  <= rs1_data;
      o_ex_rs2_data  <= rs2_data;
      o_ex_imm       <= d_imm;
      o_ex_rs1_addr  <= dinst[19:15];
      o_ex_rs2_addr  <= dinst[24:20];
      o_ex_rd        <= dinst[11:7];
      o_ex_funct3    <= dinst[14:12];
      o_ex_alu_op    <= d_alu;
      o_ex_wb_sel    <= d_wb;
      o_ex_opa_sel   <= d_opa;
      o_ex_opb_sel   <= d_opb;
      o_ex_rd_wr     <= d_rd_wr  & ~bubble;
      o_ex_mem_rd    <= d_mem_rd & ~bubble;
      o_ex_mem_wr    <= d_mem_wr & ~bubble;
      o_ex_is_branch <= d_br     & ~bubble;
      o_ex_is_jump   <= d_jmp    & ~bubble;
      o_ex_valid     <= ~bubble;
    end
  end

endmodule
